// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy bird game controller.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        CRASH   = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam int ROWS      = 8;
    localparam int SCORE_MAX = 99;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter; saturates at SCORE_MAX and never wraps.
module bcd_score_counter
    import flappy_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    localparam logic [3:0] MAX_ONES = 4'(SCORE_MAX % 10);
    localparam logic [3:0] MAX_TENS = 4'(SCORE_MAX / 10);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       w_at_max;

    assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (inc && !w_at_max) begin
            if (r_ones == 4'd9) begin
                r_ones <= '0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign ones = r_ones;
    assign tens = r_tens;

endmodule

// File: rtl/flappy_game_sequencer.sv
// Game phase sequencer: idle/play/crash/over FSM, scroll tick generation,
// column-0 collision detection and BCD scoring.
module flappy_game_sequencer
    import flappy_pkg::*;
#(
    parameter int SCROLL_PERIOD = 25000000,
    parameter int CRASH_CYCLES  = 50000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [ROWS-1:0] bird_row,
    input  logic [ROWS-1:0] pipe_col0,
    output logic            game_enable,
    output logic            scroll_tick,
    output logic            clear_field,
    output logic [3:0]      score_ones,
    output logic [3:0]      score_tens,
    output logic [1:0]      state_out,
    output logic            crash_flash
);

    localparam int TW = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
    localparam int CW = (CRASH_CYCLES > 1) ? $clog2(CRASH_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCROLL_PERIOD - 1);
    localparam logic [CW-1:0] CRASH_LAST = CW'(CRASH_CYCLES - 1);

    game_state_t r_state;
    game_state_t w_next;

    logic          r_start_q;
    logic [TW-1:0] r_tick_cnt;
    logic [CW-1:0] r_crash_cnt;
    logic          r_scroll_tick;
    logic          r_clear_field;
    logic          r_crash_flash;

    logic w_start_rise;
    logic w_collision;
    logic w_tick_wrap;
    logic w_crash_done;
    logic w_new_game;
    logic w_score_inc;
    logic w_tick_running;

    assign w_start_rise   = start & ~r_start_q;
    assign w_collision    = (r_state == PLAYING) && (|(bird_row & pipe_col0));
    assign w_tick_wrap    = (r_tick_cnt == TICK_LAST);
    assign w_crash_done   = (r_crash_cnt == CRASH_LAST);
    assign w_tick_running = (r_state == PLAYING) || (r_state == CRASH);

    // A tick with a pipe in column 0 and no collision means the bird cleared it.
    assign w_score_inc = (r_state == PLAYING) && r_scroll_tick && !w_collision && (|pipe_col0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_new_game = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_next     = PLAYING;
                    w_new_game = 1'b1;
                end
            end
            PLAYING: begin
                if (w_collision) begin
                    w_next = CRASH;
                end
            end
            CRASH: begin
                if (w_crash_done) begin
                    w_next = OVER;
                end
            end
            OVER: begin
                if (w_start_rise) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_q     <= 1'b1;
            r_tick_cnt    <= '0;
            r_crash_cnt   <= '0;
            r_scroll_tick <= 1'b0;
            r_clear_field <= 1'b0;
            r_crash_flash <= 1'b0;
        end else begin
            r_start_q     <= start;
            r_clear_field <= w_new_game;

            if (w_new_game || !w_tick_running || w_tick_wrap) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            r_scroll_tick <= (r_state == PLAYING) && w_tick_wrap && !w_collision;

            if ((r_state == CRASH) && !w_crash_done) begin
                r_crash_cnt <= r_crash_cnt + 1'b1;
            end else begin
                r_crash_cnt <= '0;
            end

            // Flash is forced low on the edge that leaves CRASH so OVER starts dark.
            if (w_next != CRASH) begin
                r_crash_flash <= 1'b0;
            end else if ((r_state == CRASH) && w_tick_wrap) begin
                r_crash_flash <= ~r_crash_flash;
            end
        end
    end

    bcd_score_counter u_score (
        .clock (clock),
        .reset (reset),
        .clear (w_new_game),
        .inc   (w_score_inc),
        .ones  (score_ones),
        .tens  (score_tens)
    );

    assign game_enable = (r_state == PLAYING);
    assign scroll_tick = r_scroll_tick;
    assign clear_field = r_clear_field;
    assign crash_flash = r_crash_flash;
    assign state_out   = r_state;

endmodule

// File: tb/tb_flappy_game_sequencer.sv
// Directed-vector bench for flappy_game_sequencer with SCROLL_PERIOD=4, CRASH_CYCLES=6.
module tb_flappy_game_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] bird_row;
    logic [7:0] pipe_col0;
    logic       game_enable;
    logic       scroll_tick;
    logic       clear_field;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [1:0] state_out;
    logic       crash_flash;

    int n_pass  = 0;
    int n_total = 0;

    flappy_game_sequencer #(
        .SCROLL_PERIOD (4),
        .CRASH_CYCLES  (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bird_row    (bird_row),
        .pipe_col0   (pipe_col0),
        .game_enable (game_enable),
        .scroll_tick (scroll_tick),
        .clear_field (clear_field),
        .score_ones  (score_ones),
        .score_tens  (score_tens),
        .state_out   (state_out),
        .crash_flash (crash_flash)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advances until scroll_tick is observed high; a timeout is a failed comparison.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (scroll_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            n_total++;
            $display("FAIL wait_tick: got no scroll_tick within 12 cycles, required one");
        end
    endtask

    task automatic start_game();
        reset     = 1'b1;
        start     = 1'b0;
        bird_row  = 8'h00;
        pipe_col0 = 8'h00;
        step();
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b1;
        bird_row  = 8'h00;
        pipe_col0 = 8'h00;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        n_total++;
        if (state_out !== 2'd0) $display("FAIL reset_state: got %0d required 0", state_out);
        else n_pass++;
        n_total++;
        if (game_enable !== 1'b0) $display("FAIL reset_enable: got %b required 0", game_enable);
        else n_pass++;
        n_total++;
        if (scroll_tick !== 1'b0 || clear_field !== 1'b0 || crash_flash !== 1'b0)
            $display("FAIL reset_pulses: got tick=%b clear=%b flash=%b required all 0",
                     scroll_tick, clear_field, crash_flash);
        else n_pass++;
        n_total++;
        if ({score_tens, score_ones} !== 8'h00)
            $display("FAIL reset_score: got %h%h required 00", score_tens, score_ones);
        else n_pass++;
    endtask

    task automatic test_start_and_ticks();
        logic exp_tick;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if (state_out !== 2'd1 || game_enable !== 1'b1)
            $display("FAIL start_enter: got state=%0d en=%b required 1/1", state_out, game_enable);
        else n_pass++;
        n_total++;
        if (clear_field !== 1'b1) $display("FAIL start_clear_hi: got %b required 1", clear_field);
        else n_pass++;
        n_total++;
        if ({score_tens, score_ones} !== 8'h00)
            $display("FAIL start_score: got %h%h required 00", score_tens, score_ones);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_tick = ((k % 4) == 0);
            n_total++;
            if (scroll_tick !== exp_tick)
                $display("FAIL tick_cycle%0d: got %b required %b", k, scroll_tick, exp_tick);
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if (clear_field !== 1'b0) $display("FAIL start_clear_lo: got %b required 0", clear_field);
                else n_pass++;
            end
        end
    endtask

    task automatic test_scoring();
        start_game();
        bird_row  = 8'h08;
        pipe_col0 = 8'hF0;
        wait_tick();
        step();
        n_total++;
        if ({score_tens, score_ones} !== 8'h01)
            $display("FAIL score_first: got %h%h required 01", score_tens, score_ones);
        else n_pass++;
        wait_tick();
        step();
        n_total++;
        if ({score_tens, score_ones} !== 8'h02)
            $display("FAIL score_second: got %h%h required 02", score_tens, score_ones);
        else n_pass++;
        pipe_col0 = 8'h00;
        wait_tick();
        step();
        n_total++;
        if ({score_tens, score_ones} !== 8'h02)
            $display("FAIL score_empty_col: got %h%h required 02", score_tens, score_ones);
        else n_pass++;
    endtask

    task automatic test_bcd_carry_saturate();
        start_game();
        bird_row  = 8'h08;
        pipe_col0 = 8'hF0;
        repeat (9) begin
            wait_tick();
            step();
        end
        n_total++;
        if ({score_tens, score_ones} !== 8'h09)
            $display("FAIL score_nine: got %h%h required 09", score_tens, score_ones);
        else n_pass++;
        wait_tick();
        step();
        n_total++;
        if (score_tens !== 4'd1 || score_ones !== 4'd0)
            $display("FAIL score_carry: got %h%h required 10", score_tens, score_ones);
        else n_pass++;
        repeat (94) begin
            wait_tick();
            step();
        end
        n_total++;
        if ({score_tens, score_ones} !== 8'h99)
            $display("FAIL score_saturate: got %h%h required 99", score_tens, score_ones);
        else n_pass++;
        n_total++;
        if (state_out !== 2'd1) $display("FAIL saturate_state: got %0d required 1", state_out);
        else n_pass++;
    endtask

    task automatic test_crash();
        logic exp_flash;
        start_game();
        bird_row  = 8'h08;
        pipe_col0 = 8'hF0;
        wait_tick();
        step();
        n_total++;
        if ({score_tens, score_ones} !== 8'h01)
            $display("FAIL crash_prescore: got %h%h required 01", score_tens, score_ones);
        else n_pass++;
        bird_row  = 8'h10;
        pipe_col0 = 8'h00;
        wait_tick();
        pipe_col0 = 8'h10;
        step();
        pipe_col0 = 8'h00;
        n_total++;
        if (state_out !== 2'd2 || game_enable !== 1'b0)
            $display("FAIL crash_enter: got state=%0d en=%b required 2/0", state_out, game_enable);
        else n_pass++;
        n_total++;
        if ({score_tens, score_ones} !== 8'h01)
            $display("FAIL crash_no_score: got %h%h required 01", score_tens, score_ones);
        else n_pass++;
        n_total++;
        if (crash_flash !== 1'b0 || scroll_tick !== 1'b0)
            $display("FAIL crash_cycle0: got flash=%b tick=%b required 0/0", crash_flash, scroll_tick);
        else n_pass++;
        for (int j = 1; j <= 5; j++) begin
            step();
            exp_flash = (j >= 3);
            n_total++;
            if (state_out !== 2'd2 || crash_flash !== exp_flash || scroll_tick !== 1'b0)
                $display("FAIL crash_cycle%0d: got state=%0d flash=%b tick=%b required 2/%b/0",
                         j, state_out, crash_flash, scroll_tick, exp_flash);
            else n_pass++;
        end
        step();
        n_total++;
        if (state_out !== 2'd3 || crash_flash !== 1'b0 || game_enable !== 1'b0)
            $display("FAIL crash_to_over: got state=%0d flash=%b en=%b required 3/0/0",
                     state_out, crash_flash, game_enable);
        else n_pass++;
    endtask

    task automatic test_over_restart();
        start = 1'b1;
        step();
        n_total++;
        if (state_out !== 2'd0 || {score_tens, score_ones} !== 8'h01)
            $display("FAIL over_to_idle: got state=%0d score=%h%h required 0/01",
                     state_out, score_tens, score_ones);
        else n_pass++;
        step();
        n_total++;
        if (state_out !== 2'd0) $display("FAIL idle_held_start: got %0d required 0", state_out);
        else n_pass++;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if (state_out !== 2'd1 || clear_field !== 1'b1 || {score_tens, score_ones} !== 8'h00)
            $display("FAIL restart_play: got state=%0d clear=%b score=%h%h required 1/1/00",
                     state_out, clear_field, score_tens, score_ones);
        else n_pass++;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_total++;
        if (state_out !== 2'd1 || clear_field !== 1'b0 || game_enable !== 1'b1)
            $display("FAIL play_ignores_start: got state=%0d clear=%b en=%b required 1/0/1",
                     state_out, clear_field, game_enable);
        else n_pass++;
    endtask

    task automatic test_midgame_reset();
        start_game();
        bird_row  = 8'h08;
        pipe_col0 = 8'hF0;
        repeat (5) begin
            wait_tick();
            step();
        end
        n_total++;
        if ({score_tens, score_ones} !== 8'h05)
            $display("FAIL midreset_prescore: got %h%h required 05", score_tens, score_ones);
        else n_pass++;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if (state_out !== 2'd0 || {score_tens, score_ones} !== 8'h00)
            $display("FAIL midreset_state: got state=%0d score=%h%h required 0/00",
                     state_out, score_tens, score_ones);
        else n_pass++;
        n_total++;
        if (game_enable !== 1'b0 || scroll_tick !== 1'b0)
            $display("FAIL midreset_outputs: got en=%b tick=%b required 0/0", game_enable, scroll_tick);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start_and_ticks();
        test_scoring();
        test_bcd_carry_saturate();
        test_crash();
        test_over_restart();
        test_midgame_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
